// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared definitions for the bit-serial adder: FSM state encoding
//            and the default operand width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  // Default operand/sum width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_if
// Purpose  : Request/response bundle between an issuing controller and the
//            bit-serial adder.
// Ports    : start, a, b, ci  - request (controller -> adder)
//            busy, done, sum, co - status/result (adder -> controller)
//            modport master : controller side
//            modport slave  : adder side
// Revision : 1.0 - initial release
// ============================================================================
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output start, a, b, ci,
    input  busy, done, sum, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, sum, co
  );

endinterface : serial_adder_if
`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : serial_fa_cell
// Purpose  : One-bit combinational full adder built from gate primitives.
// Ports    : a, b, ci (in)  - addend bits and carry-in
//            s  (out)       - sum bit, a ^ b ^ ci
//            co (out)       - carry-out, majority(a, b, ci)
// Revision : 1.0 - initial release
// ============================================================================
module serial_fa_cell (
  output wire s,
  output wire co,
  input  wire a,
  input  wire b,
  input  wire ci
);

  wire w_axb;
  wire w_ab;
  wire w_caxb;

  xor u_xor_ab  (w_axb, a, b);
  xor u_xor_s   (s, w_axb, ci);
  and u_and_ab  (w_ab, a, b);
  // ci & (a ^ b) together with a & b covers every majority case.
  and u_and_cax (w_caxb, ci, w_axb);
  or  u_or_co   (co, w_ab, w_caxb);

endmodule : serial_fa_cell
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder. Captures two WIDTH-bit operands and a carry-in
//            on an accepted start, then adds them LSB-first, one bit per
//            clock, through a single full-adder cell with a registered carry.
// Ports    : clk   (in)  - rising-edge clock
//            reset (in)  - synchronous, active-high reset
//            bus   (slave modport of serial_adder_if)
//              start/a/b/ci  - request, sampled only in IDLE or DONE
//              busy          - high while bits are processed
//              done          - one-cycle pulse, sum/co valid
//              sum/co        - result, held until the next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  wire             clk,
  input  wire             reset,
  serial_adder_if.slave   bus
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sha;
  logic [WIDTH-1:0] r_shb;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_co;

  logic             w_accept;
  logic             w_last;
  logic             w_s_bit;
  logic             w_c_out;
  logic [WIDTH-1:0] w_sum_shift;

  serial_fa_cell u_cell (
    .s  (w_s_bit),
    .co (w_c_out),
    .a  (r_sha[0]),
    .b  (r_shb[0]),
    .ci (r_carry)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts the first
  // (LSB) bit has reached position 0.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign w_sum_shift = w_s_bit;
    end else begin : g_sum_wn
      assign w_sum_shift = {w_s_bit, r_sum[WIDTH-1:1]};
    end
  endgenerate

  // start only counts while idle or finishing; it is ignored during RUN.
  assign w_accept = bus.start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = bus.start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sha   <= '0;
      r_shb   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_co    <= 1'b0;
    end else if (w_accept) begin
      r_sha   <= bus.a;
      r_shb   <= bus.b;
      r_carry <= bus.ci;
      r_cnt   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum   <= w_sum_shift;
      r_sha   <= r_sha >> 1;
      r_shb   <= r_shb >> 1;
      r_carry <= w_c_out;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_co <= w_c_out;
      end
    end
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);
  assign bus.sum  = r_sum;
  assign bus.co   = r_co;

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(1)) bus1 ();

  serial_adder #(.WIDTH(8), .CNT_W(6)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  serial_adder #(.WIDTH(1), .CNT_W(6)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs [6];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called just after an accepting posedge (or after k RUN negedges).
  // Returns the negedge index at which done was first seen (0 = timeout)
  // and the number of busy negedges before it.
  task automatic wait_done8(output int lat, output int bc);
    lat = 0;
    bc  = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus8.done === 1'b1) begin
        lat = n;
        break;
      end
      if (bus8.busy === 1'b1) bc++;
    end
  endtask

  task automatic do_op8(input vec_t v, input string name);
    int lat;
    int bc;
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = v.a;
    bus8.b     = v.b;
    bus8.ci    = v.ci;
    @(posedge clk);
    #1;
    bus8.start = 1'b0;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.ci    = 1'($urandom);
    wait_done8(lat, bc);
    check({name, " latency"}, lat, 9);
    check({name, " busy cycles"}, bc, 8);
    check({name, " sum"}, {24'd0, bus8.sum}, {24'd0, v.s});
    check({name, " co"}, {31'd0, bus8.co}, {31'd0, v.co});
    @(negedge clk);
    check({name, " done width"}, {31'd0, bus8.done}, 32'd0);
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    logic [1:0] exp1 [8];

    vecs[0] = '{a: 8'h00, b: 8'h00, ci: 1'b0, s: 8'h00, co: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, ci: 1'b0, s: 8'h00, co: 1'b1};
    vecs[2] = '{a: 8'h5A, b: 8'hA5, ci: 1'b1, s: 8'h00, co: 1'b1};
    vecs[3] = '{a: 8'h3C, b: 8'h0F, ci: 1'b0, s: 8'h4B, co: 1'b0};
    vecs[4] = '{a: 8'h7F, b: 8'h01, ci: 1'b1, s: 8'h81, co: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, ci: 1'b1, s: 8'hFF, co: 1'b1};
    exp1 = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

    reset      = 1'b1;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.ci = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.ci = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset busy", {31'd0, bus8.busy}, 32'd0);
    check("reset done", {31'd0, bus8.done}, 32'd0);
    check("reset sum",  {24'd0, bus8.sum}, 32'd0);
    check("reset co",   {31'd0, bus8.co}, 32'd0);

    // Table-driven single operations.
    for (int i = 0; i < 6; i++) begin
      do_op8(vecs[i], $sformatf("vec%0d", i));
    end

    // Operands and start changed during RUN must not disturb the result.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.ci = 1'b0;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    @(negedge clk);
    bus8.a = 8'hFF; bus8.start = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    wait_done8(lat, bc);
    check("midrun latency", lat, 8);
    check("midrun busy cycles", bc, 7);
    check("midrun sum", {24'd0, bus8.sum}, 32'h02);
    check("midrun co", {31'd0, bus8.co}, 32'd0);
    @(negedge clk);
    check("midrun extra done", {31'd0, bus8.done}, 32'd0);
    check("midrun idle busy", {31'd0, bus8.busy}, 32'd0);

    // start held high: second operation accepted straight from DONE.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.ci = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b busy", {31'd0, bus8.busy}, 32'd1);
    bus8.a = 8'h80; bus8.b = 8'h80;
    wait_done8(lat, bc);
    check("b2b first latency", lat, 8);
    check("b2b first busy cycles", bc, 7);
    check("b2b first sum", {24'd0, bus8.sum}, 32'h30);
    check("b2b first co", {31'd0, bus8.co}, 32'd0);
    wait_done8(lat, bc);
    check("b2b second latency", lat, 9);
    check("b2b second busy cycles", bc, 8);
    check("b2b second sum", {24'd0, bus8.sum}, 32'h00);
    check("b2b second co", {31'd0, bus8.co}, 32'd1);
    bus8.start = 1'b0;
    @(negedge clk);
    check("b2b done width", {31'd0, bus8.done}, 32'd0);
    check("b2b back to idle", {31'd0, bus8.busy}, 32'd0);

    // Reset in the 4th RUN cycle abandons the operation.
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.ci = 1'b1;
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", {31'd0, bus8.busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", {31'd0, bus8.busy}, 32'd0);
    check("midreset done", {31'd0, bus8.done}, 32'd0);
    check("midreset sum",  {24'd0, bus8.sum}, 32'd0);
    check("midreset co",   {31'd0, bus8.co}, 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done !== 1'b0) seen++;
    end
    check("midreset no done", seen, 0);
    do_op8(vecs[3], "post-reset");

    // WIDTH=1: full truth table, new request every 2 cycles.
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus1.start = 1'b1;
      bus1.a     = 1'(i >> 2);
      bus1.b     = 1'(i >> 1);
      bus1.ci    = 1'(i);
      @(negedge clk);
      check($sformatf("w1 busy %0d", i), {31'd0, bus1.busy}, 32'd1);
      @(negedge clk);
      check($sformatf("w1 done %0d", i), {31'd0, bus1.done}, 32'd1);
      check($sformatf("w1 result %0d", i), {30'd0, bus1.co, bus1.sum}, {30'd0, exp1[i]});
    end
    bus1.start = 1'b0;
    @(negedge clk);
    check("w1 idle done", {31'd0, bus1.done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule : tb_serial_adder
`default_nettype wire
